// File: rtl/tvm_pkg.sv
// tvm_pkg: shared FSM state encoding and 2-of-3 majority helper for triple_vote_monitor
package tvm_pkg;
  typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, REPORT = 2'b10} state_t;
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction
endpackage

// File: rtl/tvm_vote_reg.sv
// tvm_vote_reg: registered 2-of-3 majority of the replicated flag plus combinational disagreement detect
module tvm_vote_reg
  import tvm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] in,
  output logic       voted,
  output logic       mismatch
);
  assign mismatch = (in != 3'b000) && (in != 3'b111);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) voted <= 1'b0;
    else voted <= maj3(in);
endmodule

// File: rtl/triple_vote_monitor.sv
// triple_vote_monitor: votes a replicated flag, reports runs of 1s as handshaked events.
// Optional macro TRIPLE_VOTE_MONITOR_MISMATCH_CNT_EN adds the saturating disagreement counter.
module triple_vote_monitor
  import tvm_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int MIN_RUN = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [2:0]       in,
  input  logic             evt_ready,
  output logic             voted,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_len,
  output logic [CNT_W-1:0] mismatch_cnt,
  output logic             ovf
);
  localparam logic [CNT_W-1:0] MAX_CNT = '1;
  localparam logic [CNT_W-1:0] MIN_LEN = CNT_W'(MIN_RUN);
  state_t           state;
  logic [CNT_W-1:0] run_len;
  logic             voted_prev, mismatch, start;
  tvm_vote_reg u_vote (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .voted    (voted),
    .mismatch (mismatch)
  );
  // Runs begin only on a rising voted; a run still high after a dropped event stays discarded.
  assign start = voted && !voted_prev;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      run_len    <= '0;
      evt_len    <= '0;
      evt_valid  <= 1'b0;
      ovf        <= 1'b0;
      voted_prev <= 1'b0;
    end else begin
      voted_prev <= voted;
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          run_len <= CNT_W'(1);
        end
        RUN: if (voted) run_len <= (run_len == MAX_CNT) ? run_len : run_len + 1'b1;
        else if (run_len >= MIN_LEN) begin
          state     <= REPORT;
          evt_len   <= run_len;
          evt_valid <= 1'b1;
        end else state <= IDLE;
        REPORT: begin
          if (start) ovf <= 1'b1;
          if (evt_ready) begin
            state     <= IDLE;
            evt_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
`ifdef TRIPLE_VOTE_MONITOR_MISMATCH_CNT_EN
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mismatch_cnt <= '0;
    else if (mismatch && mismatch_cnt != MAX_CNT) mismatch_cnt <= mismatch_cnt + 1'b1;
`else
  logic unused_mismatch;
  assign unused_mismatch = mismatch;
  assign mismatch_cnt = '0;
`endif
endmodule

// File: tb/tb_triple_vote_monitor.sv
// tb_triple_vote_monitor: directed and random stimulus checked against a run-level reference model
module tb_triple_vote_monitor;
  localparam int CNT_W = 8, MIN_RUN = 2, MAXV = (1 << CNT_W) - 1;
  logic clk = 1'b0, rst_n = 1'b0, evt_ready = 1'b0;
  logic [2:0] in = 3'b000;
  logic voted, evt_valid, ovf;
  logic [CNT_W-1:0] evt_len, mismatch_cnt;
  int checks = 0, failures = 0;
  int mv, mvp, pend, evlen, len, disc, movf, mcnt;
  always #5 clk = ~clk;
  triple_vote_monitor #(.CNT_W(CNT_W), .MIN_RUN(MIN_RUN)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in           (in),
    .evt_ready    (evt_ready),
    .voted        (voted),
    .evt_valid    (evt_valid),
    .evt_len      (evt_len),
    .mismatch_cnt (mismatch_cnt),
    .ovf          (ovf)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic model_reset();
    mv = 0; mvp = 0; pend = 0; evlen = 0; len = 0; disc = 0; movf = 0; mcnt = 0;
  endtask
  task automatic compare();
    check("voted", 32'(voted), mv);
    check("evt_valid", 32'(evt_valid), pend);
    check("evt_len", 32'(evt_len), evlen);
    check("ovf", 32'(ovf), movf);
`ifdef TRIPLE_VOTE_MONITOR_MISMATCH_CNT_EN
    check("mismatch_cnt", 32'(mismatch_cnt), mcnt);
`else
    check("mismatch_cnt", 32'(mismatch_cnt), 0);
`endif
  endtask
  // One clock edge of the reference: runs are maximal stretches of 1s in the voted stream.
  task automatic model_edge(input logic [2:0] i, input logic r);
    int pend_before;
    pend_before = pend;
    if (pend_before != 0 && r) pend = 0;
    if (mv != 0 && mvp == 0) begin
      if (pend_before != 0) begin movf = 1; disc = 1; end
      else begin disc = 0; len = 1; end
    end else if (mv != 0) len = (len < MAXV) ? len + 1 : len;
    else if (mvp != 0 && disc == 0 && len >= MIN_RUN) begin pend = 1; evlen = len; end
    mvp = mv;
    mv = (int'(i[0]) + int'(i[1]) + int'(i[2]) >= 2) ? 1 : 0;
    if (i != 3'b000 && i != 3'b111) mcnt = (mcnt < MAXV) ? mcnt + 1 : mcnt;
  endtask
  task automatic step(input logic [2:0] i, input logic r);
    in = i;
    evt_ready = r;
    @(posedge clk);
    model_edge(i, r);
    @(negedge clk);
    compare();
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    compare();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    logic hi;
    model_reset();
    #1 compare();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) step(3'b111, 1'b1);
    repeat (4) step(3'b000, 1'b1);
    step(3'b111, 1'b0);
    repeat (3) step(3'b000, 1'b0);
    for (int k = 0; k < 5; k++) step((k % 2 == 0) ? 3'b110 : 3'b001, 1'b0);
    repeat (2) step(3'b000, 1'b0);
    repeat (3) step(3'b111, 1'b0);
    repeat (2) step(3'b000, 1'b0);
    repeat (3) step(3'b111, 1'b0);
    repeat (3) step(3'b000, 1'b0);
    step(3'b000, 1'b1);
    repeat (300) step(3'b111, 1'b1);
    repeat (3) step(3'b000, 1'b0);
    step(3'b000, 1'b1);
    repeat (3) step(3'b111, 1'b0);
    repeat (2) step(3'b000, 1'b0);
    do_reset();
    repeat (3) step(3'b111, 1'b1);
    repeat (4) step(3'b000, 1'b1);
    hi = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) hi = ~hi;
      if ($urandom_range(0, 399) == 0) do_reset();
      step(($urandom_range(0, 4) == 0) ? 3'($urandom) : {3{hi}}, $urandom_range(0, 2) == 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/triple_vote_monitor.md
TRIPLE_VOTE_MONITOR -- requirements
Module: triple_vote_monitor

Interface
REQ-001 Parameter CNT_W, default 8: width of the run-length and mismatch counters; legal range 2..16.
REQ-002 Parameter MIN_RUN, default 2: minimum run length reported as an event; legal range 1..2^CNT_W-1.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in  input  3  replicated flag triple from the upstream triple-register stage.
REQ-006 evt_ready  input  1  consumer accepts the current event.
REQ-007 voted  output  1  registered 2-of-3 majority of in.
REQ-008 evt_valid  output  1  event pending.
REQ-009 evt_len  output  CNT_W  length of the reported run, in cycles.
REQ-010 mismatch_cnt  output  CNT_W  count of cycles where the three bits of in disagreed.
REQ-011 ovf  output  1  sticky flag: a run started while an event was pending.

Function
REQ-012 voted SHALL update every edge to maj(in[0],in[1],in[2]), giving 1-cycle latency.
REQ-013 A mismatch (in not 3'b000 and not 3'b111) at an edge SHALL increment mismatch_cnt, saturating at 2^CNT_W-1.
REQ-014 The FSM SHALL have three states, IDLE, RUN and REPORT, and SHALL sample the registered voted, not in.
REQ-015 IDLE: voted==1 SHALL move to RUN with run_len=1; otherwise stay in IDLE.
REQ-016 RUN: voted==1 SHALL increment run_len, saturating at 2^CNT_W-1.
REQ-017 RUN: voted==0 with run_len>=MIN_RUN SHALL move to REPORT, register evt_len=run_len and set evt_valid=1.
REQ-018 RUN: voted==0 with run_len<MIN_RUN SHALL return to IDLE with no event.
REQ-019 REPORT: evt_valid and evt_len SHALL hold stable until an edge where evt_valid&&evt_ready is true.
REQ-020 On that handshake the FSM SHALL move to IDLE and clear evt_valid in the same edge.
REQ-021 REPORT: voted==1 while voted was 0 at the previous edge (a new run start) SHALL set ovf; that run SHALL be discarded.
REQ-022 If a handshake and a run start occur at the same edge, the FSM SHALL go to IDLE, ovf SHALL be set, and the run SHALL be discarded.
REQ-023 evt_ready SHALL be ignored outside REPORT.

Reset
REQ-024 rst_n low SHALL immediately force state=IDLE, voted=0, evt_valid=0, evt_len=0, run_len=0, mismatch_cnt=0 and ovf=0.
REQ-025 Reset mid-RUN or mid-REPORT SHALL drop the pending run or event without any handshake.
REQ-026 The first edge after rst_n deasserts SHALL behave as a normal edge from IDLE.

Configuration
REQ-027 Macro TRIPLE_VOTE_MONITOR_MISMATCH_CNT_EN defined: the mismatch counter SHALL be present and behave per REQ-013.
REQ-028 Macro TRIPLE_VOTE_MONITOR_MISMATCH_CNT_EN undefined: no counter flops SHALL exist and mismatch_cnt SHALL be constant 0; all other behaviour is unchanged.

Structure
REQ-029 Shared package tvm_pkg SHALL hold the state enum (IDLE=2'b00, RUN=2'b01, REPORT=2'b10) and the maj3 function.
REQ-030 Sub-module tvm_vote_reg SHALL contain the majority register and mismatch detection.
REQ-031 The FSM and counters SHALL reside in the top module.

Verification
REQ-032 in=3'b111 for 4 edges, then 3'b000, evt_ready=1 -> evt_valid=1 for exactly 1 cycle with evt_len=4, 2 edges after in falls.
REQ-033 in=3'b111 for 1 edge with MIN_RUN=2 -> no evt_valid; FSM back in IDLE; ovf=0.
REQ-034 in alternating 3'b110/3'b001 for 5 edges -> voted follows the majority (1,0,1,0,1); mismatch_cnt=5 (macro on) or 0 (macro off).
REQ-035 evt_ready=0 held while a second run of length 3 occurs -> first evt_len held unchanged; ovf=1; second run never reported.
REQ-036 in=3'b111 for 300 edges with CNT_W=8 -> evt_len=255 (saturated).
REQ-037 rst_n pulsed low while evt_valid=1 -> all outputs 0 immediately; after release, a run of length 3 is reported normally.
